// File: rtl/stage_ex_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : stage_ex_pkg                                                    |
// | Purpose  : Shared opcodes, interstage bundle layouts and muldiv types for  |
// |            the execute stage.                                              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package stage_ex_pkg;

  // ALU operation codes carried in id2ex.alu_opt
  localparam logic [4:0] ALU_OPT_DISABLE = 5'd0;
  localparam logic [4:0] ALU_OPT_ADDU    = 5'd1;
  localparam logic [4:0] ALU_OPT_SUBU    = 5'd2;
  localparam logic [4:0] ALU_OPT_AND     = 5'd3;
  localparam logic [4:0] ALU_OPT_OR      = 5'd4;
  localparam logic [4:0] ALU_OPT_XOR     = 5'd5;
  localparam logic [4:0] ALU_OPT_NOR     = 5'd6;
  localparam logic [4:0] ALU_OPT_SLT     = 5'd7;
  localparam logic [4:0] ALU_OPT_SLTU    = 5'd8;
  localparam logic [4:0] ALU_OPT_SLL     = 5'd9;
  localparam logic [4:0] ALU_OPT_SRL     = 5'd10;
  localparam logic [4:0] ALU_OPT_SRA     = 5'd11;
  localparam logic [4:0] ALU_OPT_SLLV    = 5'd12;
  localparam logic [4:0] ALU_OPT_SRLV    = 5'd13;
  localparam logic [4:0] ALU_OPT_SRAV    = 5'd14;
  localparam logic [4:0] ALU_OPT_MFHI    = 5'd15;
  localparam logic [4:0] ALU_OPT_MFLO    = 5'd16;
  localparam logic [4:0] ALU_OPT_MTHI    = 5'd17;
  localparam logic [4:0] ALU_OPT_MTLO    = 5'd18;
  localparam logic [4:0] ALU_OPT_MULT    = 5'd19;
  localparam logic [4:0] ALU_OPT_MULTU   = 5'd20;
  localparam logic [4:0] ALU_OPT_DIV     = 5'd21;
  localparam logic [4:0] ALU_OPT_DIVU    = 5'd22;

  // Second operand source
  localparam logic ALU_SRC_REG = 1'b0;
  localparam logic ALU_SRC_IMM = 1'b1;

  // Branch resolution kinds
  localparam logic [1:0] BRANCH_OPT_NONE   = 2'd0;
  localparam logic [1:0] BRANCH_ON_ALU_EQZ = 2'd1;

  // Memory access kinds, passed through to MEM untouched
  localparam logic [2:0] MEM_OPT_NONE = 3'd0;
  localparam logic [2:0] MEM_OPT_LW   = 3'd1;
  localparam logic [2:0] MEM_OPT_SW   = 3'd2;
  localparam logic [2:0] MEM_OPT_LB   = 3'd3;
  localparam logic [2:0] MEM_OPT_SB   = 3'd4;

  // Writeback source select
  localparam logic WB_SRC_ALU = 1'b0;
  localparam logic WB_SRC_MEM = 1'b1;

  // ID->EX bundle, MSB first
  typedef struct packed {
    logic [4:0]  alu_opt;
    logic        alu_src;
    logic [15:0] alu_sa_imm;
    logic [31:0] reg1_data;
    logic [31:0] reg2_data;
    logic [1:0]  branch_opt;
    logic [31:0] branch_dest;
    logic        wb_src;
    logic [4:0]  wb_reg_addr;
    logic [2:0]  mem_opt;
  } id2ex_t;

  // EX->MEM bundle, MSB first
  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_opt;
    logic        wb_src;
    logic [4:0]  wb_reg_addr;
  } ex2mem_t;

  localparam int ID2EX_WIRE_WIDTH  = $bits(id2ex_t);
  localparam int EX2MEM_WIRE_WIDTH = $bits(ex2mem_t);

  // Multiply/divide unit operation and state
  typedef enum logic [1:0] {
    MD_OP_MULT  = 2'd0,
    MD_OP_MULTU = 2'd1,
    MD_OP_DIV   = 2'd2,
    MD_OP_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  // True for the ops that occupy the iterative multiply/divide unit
  function automatic logic is_muldiv(input logic [4:0] opt);
    return (opt == ALU_OPT_MULT) || (opt == ALU_OPT_MULTU) ||
           (opt == ALU_OPT_DIV)  || (opt == ALU_OPT_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stage_ex_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : stage_ex_muldiv_unit                                            |
// | Purpose  : Iterative radix-2 multiply / restoring divide with HI/LO regs.  |
// |            Signed ops run on magnitudes and fix up signs on the last step. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module stage_ex_muldiv_unit
  import stage_ex_pkg::*;
#(
  parameter int          MULDIV_ITER = 32,
  parameter logic [31:0] DIV0_QUOT   = 32'hFFFF_FFFF,
  parameter logic [31:0] HILO_RST    = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi_we,
  input  logic        mtlo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int             CNT_W    = (MULDIV_ITER > 1) ? $clog2(MULDIV_ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULDIV_ITER - 1);

  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [63:0]      acc;        // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [31:0]      opnd;       // multiplicand or divisor magnitude
  logic [31:0]      dividend;   // raw dividend, returned in HI on divide-by-zero
  logic             is_div;
  logic             neg_res;
  logic             neg_rem;
  logic             div0;

  logic        op_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_top;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] div_next;
  logic [63:0] step_next;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  assign busy = (state == MD_RUN);

  // Operand magnitudes and sign info captured on accept
  always_comb begin
    op_signed = (op == MD_OP_MULT) || (op == MD_OP_DIV);
    a_neg     = op_signed & a[31];
    b_neg     = op_signed & b[31];
    a_mag     = a_neg ? (~a + 32'd1) : a;
    b_mag     = b_neg ? (~b + 32'd1) : b;
  end

  // One shift-add or restoring-subtract step, plus sign fix-up of its result
  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    mul_next  = {mul_sum, acc[31:1]};
    div_top   = acc[63:31];
    div_ge    = (div_top >= {1'b0, opnd});
    div_sub   = div_top[31:0] - opnd;
    div_next  = {(div_ge ? div_sub : div_top[31:0]), acc[30:0], div_ge};
    step_next = is_div ? div_next : mul_next;
    prod_fix  = neg_res ? (~step_next + 64'd1) : step_next;
    quot_fix  = neg_res ? (~step_next[31:0] + 32'd1) : step_next[31:0];
    rem_fix   = neg_rem ? (~step_next[63:32] + 32'd1) : step_next[63:32];
  end

  // Muldiv FSM, iteration datapath and HI/LO registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= MD_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      dividend <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div0     <= 1'b0;
      hi       <= HILO_RST;
      lo       <= HILO_RST;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            state    <= MD_RUN;
            cnt      <= '0;
            acc      <= {32'd0, a_mag};
            opnd     <= b_mag;
            dividend <= a;
            is_div   <= (op == MD_OP_DIV) || (op == MD_OP_DIVU);
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div0     <= (b == 32'd0);
          end else begin
            if (mthi_we) hi <= wdata;
            if (mtlo_we) lo <= wdata;
          end
        end
        MD_RUN: begin
          acc <= step_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state <= MD_IDLE;
            if (!is_div) begin
              hi <= prod_fix[63:32];
              lo <= prod_fix[31:0];
            end else if (div0) begin
              hi <= dividend;
              lo <= DIV0_QUOT;
            end else begin
              hi <= rem_fix;
              lo <= quot_fix;
            end
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/stage_ex.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : stage_ex                                                        |
// | Purpose  : Execute stage: single-cycle ALU, branch resolution, MEM/WB      |
// |            pass-through, and front-end stall while mul/div iterates.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module stage_ex
  import stage_ex_pkg::*;
#(
  parameter int          MULDIV_ITER = 32,
  parameter logic [31:0] DIV0_QUOT   = 32'hFFFF_FFFF,
  parameter logic [31:0] HILO_RST    = 32'h0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ID2EX_WIRE_WIDTH-1:0]  interstage_id2ex,
  output logic                         stall_req,
  output logic                         branch_taken,
  output logic [31:0]                  branch_dest,
  output logic [EX2MEM_WIRE_WIDTH-1:0] interstage_ex2mem
);

  id2ex_t      id;
  ex2mem_t     ex2mem_q;
  logic        md_busy;
  logic        md_start;
  md_op_e      md_op;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        accept;
  logic        bubble;
  logic        no_wb;
  logic [31:0] op2;
  logic [4:0]  shamt;
  logic [31:0] alu_res;

  assign id                = id2ex_t'(interstage_id2ex);
  assign interstage_ex2mem = ex2mem_q;
  assign stall_req         = md_busy;
  assign accept            = !md_busy;
  assign bubble            = md_busy || (id.alu_opt == ALU_OPT_DISABLE);
  assign md_start          = accept && is_muldiv(id.alu_opt);
  assign no_wb             = is_muldiv(id.alu_opt) ||
                             (id.alu_opt == ALU_OPT_MTHI) || (id.alu_opt == ALU_OPT_MTLO);

  // Map the decoded opcode onto the muldiv unit's op field
  always_comb begin
    md_op = MD_OP_MULT;
    case (id.alu_opt)
      ALU_OPT_MULTU: md_op = MD_OP_MULTU;
      ALU_OPT_DIV:   md_op = MD_OP_DIV;
      ALU_OPT_DIVU:  md_op = MD_OP_DIVU;
      default:       md_op = MD_OP_MULT;
    endcase
  end

  // Operand selection and single-cycle ALU
  always_comb begin
    op2   = (id.alu_src == ALU_SRC_REG) ? id.reg2_data
                                        : {{16{id.alu_sa_imm[15]}}, id.alu_sa_imm};
    shamt = ((id.alu_opt == ALU_OPT_SLLV) || (id.alu_opt == ALU_OPT_SRLV) ||
             (id.alu_opt == ALU_OPT_SRAV)) ? id.reg1_data[4:0] : id.alu_sa_imm[4:0];
    alu_res = 32'd0;
    case (id.alu_opt)
      ALU_OPT_ADDU:                alu_res = id.reg1_data + op2;
      ALU_OPT_SUBU:                alu_res = id.reg1_data - op2;
      ALU_OPT_AND:                 alu_res = id.reg1_data & op2;
      ALU_OPT_OR:                  alu_res = id.reg1_data | op2;
      ALU_OPT_XOR:                 alu_res = id.reg1_data ^ op2;
      ALU_OPT_NOR:                 alu_res = ~(id.reg1_data | op2);
      ALU_OPT_SLT:                 alu_res = {31'd0, ($signed(id.reg1_data) < $signed(op2))};
      ALU_OPT_SLTU:                alu_res = {31'd0, (id.reg1_data < op2)};
      ALU_OPT_SLL, ALU_OPT_SLLV:   alu_res = op2 << shamt;
      ALU_OPT_SRL, ALU_OPT_SRLV:   alu_res = op2 >> shamt;
      ALU_OPT_SRA, ALU_OPT_SRAV:   alu_res = $unsigned($signed(op2) >>> shamt);
      ALU_OPT_MFHI:                alu_res = hi;
      ALU_OPT_MFLO:                alu_res = lo;
      default:                     alu_res = 32'd0;
    endcase
  end

  // Register the EX->MEM bundle and branch resolution
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex2mem_q     <= '0;
      branch_taken <= 1'b0;
      branch_dest  <= 32'd0;
    end else if (bubble) begin
      ex2mem_q     <= '0;
      branch_taken <= 1'b0;
      branch_dest  <= 32'd0;
    end else begin
      ex2mem_q.alu_result  <= alu_res;
      ex2mem_q.mem_wdata   <= id.reg2_data;
      ex2mem_q.mem_opt     <= id.mem_opt;
      ex2mem_q.wb_src      <= id.wb_src;
      ex2mem_q.wb_reg_addr <= no_wb ? 5'd0 : id.wb_reg_addr;
      branch_taken         <= (id.branch_opt == BRANCH_ON_ALU_EQZ) && (alu_res == 32'd0);
      branch_dest          <= id.branch_dest;
    end
  end

  stage_ex_muldiv_unit #(
    .MULDIV_ITER (MULDIV_ITER),
    .DIV0_QUOT   (DIV0_QUOT),
    .HILO_RST    (HILO_RST)
  ) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .start   (md_start),
    .op      (md_op),
    .a       (id.reg1_data),
    .b       (id.reg2_data),
    .mthi_we (accept && (id.alu_opt == ALU_OPT_MTHI)),
    .mtlo_we (accept && (id.alu_opt == ALU_OPT_MTLO)),
    .wdata   (id.reg1_data),
    .busy    (md_busy),
    .hi      (hi),
    .lo      (lo)
  );

endmodule
`default_nettype wire

// File: tb/tb_stage_ex.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_stage_ex                                                     |
// | Purpose  : Directed self-checking bench for stage_ex with a scoreboard of  |
// |            expected EX->MEM outputs.                                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_stage_ex;
  import stage_ex_pkg::*;

  localparam int ITER = 32;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_opt;
    logic [4:0]  wb;
    logic        taken;
    logic [31:0] dest;
  } exp_t;

  logic                         clk;
  logic                         rst;
  id2ex_t                       id_in;
  logic [ID2EX_WIRE_WIDTH-1:0]  id_bits;
  logic [EX2MEM_WIRE_WIDTH-1:0] ex_bits;
  ex2mem_t                      out;
  logic                         stall_req;
  logic                         branch_taken;
  logic [31:0]                  branch_dest;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    passed = 0;

  assign id_bits = id_in;
  assign out     = ex2mem_t'(ex_bits);

  stage_ex dut (
    .clk               (clk),
    .rst               (rst),
    .interstage_id2ex  (id_bits),
    .stall_req         (stall_req),
    .branch_taken      (branch_taken),
    .branch_dest       (branch_dest),
    .interstage_ex2mem (ex_bits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  function automatic id2ex_t mk(input logic [4:0] opt, input logic src, input logic [15:0] imm,
                                input logic [31:0] r1, input logic [31:0] r2,
                                input logic [1:0] bopt, input logic [31:0] bdest,
                                input logic [4:0] wb, input logic [2:0] mem);
    id2ex_t t;
    t.alu_opt     = opt;
    t.alu_src     = src;
    t.alu_sa_imm  = imm;
    t.reg1_data   = r1;
    t.reg2_data   = r2;
    t.branch_opt  = bopt;
    t.branch_dest = bdest;
    t.wb_src      = WB_SRC_ALU;
    t.wb_reg_addr = wb;
    t.mem_opt     = mem;
    return t;
  endfunction

  function automatic exp_t ex(input logic [31:0] alu, input logic [31:0] wdata, input logic [2:0] mem,
                              input logic [4:0] wb, input logic taken, input logic [31:0] dest);
    exp_t e;
    e.alu_result = alu;
    e.mem_wdata  = wdata;
    e.mem_opt    = mem;
    e.wb         = wb;
    e.taken      = taken;
    e.dest       = dest;
    return e;
  endfunction

  // Pop the oldest expectation and compare it with what the DUT presents now
  task automatic compare_out();
    exp_t  e;
    string t;
    if (exp_q.size() == 0) begin
      chk("scoreboard.empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk({t, ".alu_result"}, 64'(out.alu_result), 64'(e.alu_result));
      chk({t, ".wb_reg_addr"}, 64'(out.wb_reg_addr), 64'(e.wb));
      chk({t, ".mem_opt"}, 64'(out.mem_opt), 64'(e.mem_opt));
      chk({t, ".mem_wdata"}, 64'(out.mem_wdata), 64'(e.mem_wdata));
      chk({t, ".branch_taken"}, 64'(branch_taken), 64'(e.taken));
      if (e.taken) chk({t, ".branch_dest"}, 64'(branch_dest), 64'(e.dest));
    end
  endtask

  // Drive one instruction at a negedge, push its expectation, compare at the next negedge
  task automatic step(input string tag, input id2ex_t ins, input exp_t e);
    id_in = ins;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    @(negedge clk);
    compare_out();
  endtask

  // Issue a mul/div op, count stall cycles while feeding a junk instruction, then read HI and LO
  task automatic run_md(input string tag, input logic [4:0] opt, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cycles;
    step({tag, ".accept"}, mk(opt, ALU_SRC_REG, 16'h0, a, b, BRANCH_OPT_NONE, 32'h0, 5'd8, MEM_OPT_NONE),
         ex(32'h0, b, MEM_OPT_NONE, 5'd0, 1'b0, 32'h0));
    id_in  = mk(ALU_OPT_ADDU, ALU_SRC_REG, 16'h0, 32'h11, 32'h22, BRANCH_ON_ALU_EQZ, 32'h40, 5'd7, MEM_OPT_SW);
    cycles = 0;
    while (stall_req && cycles < 100) begin
      cycles++;
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".stall_bubble_wb"}, 64'(out.wb_reg_addr), 64'd0);
    end
    chk({tag, ".stall_cycles"}, 64'(cycles), 64'(ITER));
    step({tag, ".mfhi"}, mk(ALU_OPT_MFHI, ALU_SRC_REG, 16'h0, 32'h0, 32'h0, BRANCH_OPT_NONE, 32'h0, 5'd9, MEM_OPT_NONE),
         ex(exp_hi, 32'h0, MEM_OPT_NONE, 5'd9, 1'b0, 32'h0));
    step({tag, ".mflo"}, mk(ALU_OPT_MFLO, ALU_SRC_REG, 16'h0, 32'h0, 32'h0, BRANCH_OPT_NONE, 32'h0, 5'd10, MEM_OPT_NONE),
         ex(exp_lo, 32'h0, MEM_OPT_NONE, 5'd10, 1'b0, 32'h0));
  endtask

  initial begin
    rst   = 1'b0;
    id_in = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset.alu_result", 64'(out.alu_result), 64'd0);
    chk("reset.wb_reg_addr", 64'(out.wb_reg_addr), 64'd0);
    chk("reset.mem_opt", 64'(out.mem_opt), 64'(MEM_OPT_NONE));
    chk("reset.branch_taken", 64'(branch_taken), 64'd0);
    chk("reset.branch_dest", 64'(branch_dest), 64'd0);
    chk("reset.stall_req", 64'(stall_req), 64'd0);
    rst = 1'b1;

    // Single-cycle ALU
    step("addu_wrap", mk(ALU_OPT_ADDU, ALU_SRC_REG, 16'h0, 32'h7FFF_FFFF, 32'h1, BRANCH_OPT_NONE, 32'h0, 5'd3, MEM_OPT_NONE),
         ex(32'h8000_0000, 32'h1, MEM_OPT_NONE, 5'd3, 1'b0, 32'h0));
    step("slt", mk(ALU_OPT_SLT, ALU_SRC_REG, 16'h0, 32'hFFFF_FFFF, 32'h1, BRANCH_OPT_NONE, 32'h0, 5'd4, MEM_OPT_NONE),
         ex(32'h1, 32'h1, MEM_OPT_NONE, 5'd4, 1'b0, 32'h0));
    step("sltu", mk(ALU_OPT_SLTU, ALU_SRC_REG, 16'h0, 32'hFFFF_FFFF, 32'h1, BRANCH_OPT_NONE, 32'h0, 5'd4, MEM_OPT_NONE),
         ex(32'h0, 32'h1, MEM_OPT_NONE, 5'd4, 1'b0, 32'h0));
    step("sra", mk(ALU_OPT_SRA, ALU_SRC_REG, 16'h0004, 32'h0, 32'h8000_0000, BRANCH_OPT_NONE, 32'h0, 5'd5, MEM_OPT_NONE),
         ex(32'hF800_0000, 32'h8000_0000, MEM_OPT_NONE, 5'd5, 1'b0, 32'h0));
    step("srav", mk(ALU_OPT_SRAV, ALU_SRC_REG, 16'h0001, 32'h8, 32'hF000_0000, BRANCH_OPT_NONE, 32'h0, 5'd5, MEM_OPT_NONE),
         ex(32'hFFF0_0000, 32'hF000_0000, MEM_OPT_NONE, 5'd5, 1'b0, 32'h0));
    step("sll_imm31", mk(ALU_OPT_SLL, ALU_SRC_REG, 16'h001F, 32'h0, 32'h1, BRANCH_OPT_NONE, 32'h0, 5'd6, MEM_OPT_NONE),
         ex(32'h8000_0000, 32'h1, MEM_OPT_NONE, 5'd6, 1'b0, 32'h0));
    step("addu_imm_sext", mk(ALU_OPT_ADDU, ALU_SRC_IMM, 16'hFFFF, 32'd10, 32'h0000_DEAD, BRANCH_OPT_NONE, 32'h0, 5'd0, MEM_OPT_SW),
         ex(32'd9, 32'h0000_DEAD, MEM_OPT_SW, 5'd0, 1'b0, 32'h0));
    step("nor", mk(ALU_OPT_NOR, ALU_SRC_REG, 16'h0, 32'hF0F0_0000, 32'h0000_00FF, BRANCH_OPT_NONE, 32'h0, 5'd2, MEM_OPT_LW),
         ex(32'h0F0F_FF00, 32'h0000_00FF, MEM_OPT_LW, 5'd2, 1'b0, 32'h0));

    // Branch resolution
    step("beq_taken", mk(ALU_OPT_SUBU, ALU_SRC_REG, 16'h0, 32'd5, 32'd5, BRANCH_ON_ALU_EQZ, 32'h0000_1000, 5'd0, MEM_OPT_NONE),
         ex(32'h0, 32'd5, MEM_OPT_NONE, 5'd0, 1'b1, 32'h0000_1000));
    step("beq_not_taken", mk(ALU_OPT_SUBU, ALU_SRC_REG, 16'h0, 32'd5, 32'd6, BRANCH_ON_ALU_EQZ, 32'h0000_1000, 5'd0, MEM_OPT_NONE),
         ex(32'hFFFF_FFFF, 32'd6, MEM_OPT_NONE, 5'd0, 1'b0, 32'h0));
    step("bubble", mk(ALU_OPT_DISABLE, ALU_SRC_REG, 16'h0, 32'h0, 32'h0, BRANCH_ON_ALU_EQZ, 32'h80, 5'd9, MEM_OPT_LW),
         ex(32'h0, 32'h0, MEM_OPT_NONE, 5'd0, 1'b0, 32'h0));

    // HI/LO moves, no stall
    step("mthi", mk(ALU_OPT_MTHI, ALU_SRC_REG, 16'h0, 32'h0000_1234, 32'h0, BRANCH_OPT_NONE, 32'h0, 5'd2, MEM_OPT_NONE),
         ex(32'h0, 32'h0, MEM_OPT_NONE, 5'd0, 1'b0, 32'h0));
    chk("mthi.stall_req", 64'(stall_req), 64'd0);
    step("mfhi", mk(ALU_OPT_MFHI, ALU_SRC_REG, 16'h0, 32'h0, 32'h0, BRANCH_OPT_NONE, 32'h0, 5'd6, MEM_OPT_NONE),
         ex(32'h0000_1234, 32'h0, MEM_OPT_NONE, 5'd6, 1'b0, 32'h0));
    step("mtlo", mk(ALU_OPT_MTLO, ALU_SRC_REG, 16'h0, 32'h0000_5678, 32'h0, BRANCH_OPT_NONE, 32'h0, 5'd2, MEM_OPT_NONE),
         ex(32'h0, 32'h0, MEM_OPT_NONE, 5'd0, 1'b0, 32'h0));
    step("mflo", mk(ALU_OPT_MFLO, ALU_SRC_REG, 16'h0, 32'h0, 32'h0, BRANCH_OPT_NONE, 32'h0, 5'd6, MEM_OPT_NONE),
         ex(32'h0000_5678, 32'h0, MEM_OPT_NONE, 5'd6, 1'b0, 32'h0));
    chk("mflo.stall_req", 64'(stall_req), 64'd0);

    // Multiply / divide
    run_md("mult_neg3x7", ALU_OPT_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_md("div_neg7by2", ALU_OPT_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divu_by0", ALU_OPT_DIVU, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF);
    run_md("div_ovf", ALU_OPT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_md("div_7byneg2", ALU_OPT_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_md("multu_max", ALU_OPT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);

    // Reset mid-MULTU at cnt=10
    step("multu_rst.accept", mk(ALU_OPT_MULTU, ALU_SRC_REG, 16'h0, 32'h0001_0000, 32'h0001_0000, BRANCH_OPT_NONE, 32'h0, 5'd8, MEM_OPT_NONE),
         ex(32'h0, 32'h0001_0000, MEM_OPT_NONE, 5'd0, 1'b0, 32'h0));
    id_in = '0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("multu_rst.stall_before", 64'(stall_req), 64'd1);
    rst = 1'b0;
    #1;
    chk("multu_rst.stall_req", 64'(stall_req), 64'd0);
    chk("multu_rst.wb_reg_addr", 64'(out.wb_reg_addr), 64'd0);
    chk("multu_rst.branch_taken", 64'(branch_taken), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    step("post_rst_addu", mk(ALU_OPT_ADDU, ALU_SRC_REG, 16'h0, 32'd2, 32'd3, BRANCH_OPT_NONE, 32'h0, 5'd11, MEM_OPT_NONE),
         ex(32'd5, 32'd3, MEM_OPT_NONE, 5'd11, 1'b0, 32'h0));
    step("post_rst_mfhi", mk(ALU_OPT_MFHI, ALU_SRC_REG, 16'h0, 32'h0, 32'h0, BRANCH_OPT_NONE, 32'h0, 5'd12, MEM_OPT_NONE),
         ex(32'h0, 32'h0, MEM_OPT_NONE, 5'd12, 1'b0, 32'h0));
    step("post_rst_mflo", mk(ALU_OPT_MFLO, ALU_SRC_REG, 16'h0, 32'h0, 32'h0, BRANCH_OPT_NONE, 32'h0, 5'd13, MEM_OPT_NONE),
         ex(32'h0, 32'h0, MEM_OPT_NONE, 5'd13, 1'b0, 32'h0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
